gemv_lanes_core: RTL and testbench

- Parametrised successor to the fixed {32,64} GEMV core.
- Computes Y = W*X (+b) with signed int8 W/X, signed int32 bias/accumulator, and runtime-programmable dimensions.
- LANES parallel MACs consume LANES columns per cycle.
- Optional post-processing: rounding arithmetic shift with int8 saturation (requant), then ReLU.
- Sits behind the same sequential-write / sequential-read register interface used by the existing accelerator wrappers.

---
 rtl/gemv_lanes_core.sv | 212 +++++++++++++++++++++
 tb/tb_gemv_lanes_core.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemv_lanes_core.sv
// rtl/gemv_lanes_core.sv - LANES-wide int8 GEMV engine with bias, requant and ReLU
module gemv_lanes_core #(
  parameter int MAX_LEN = 64,
  parameter int MAX_OUT = 64,
  parameter int LANES   = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     x_wr_en,
  input  logic [7:0]               x_wr_data,
  input  logic                     w_wr_en,
  input  logic [7:0]               w_wr_data,
  input  logic                     b_wr_en,
  input  logic [31:0]              b_wr_data,
  input  logic [$clog2(MAX_LEN):0] cfg_len,
  input  logic [$clog2(MAX_OUT):0] cfg_out,
  input  logic                     bias_en,
  input  logic                     requant_en,
  input  logic [4:0]               shift,
  input  logic                     relu_en,
  input  logic                     start,
  input  logic                     clear_done,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err,
  input  logic                     y_rd_en,
  output logic [31:0]              y_rd_data
);

  localparam int LW   = $clog2(MAX_LEN) + 1;
  localparam int OW   = $clog2(MAX_OUT) + 1;
  localparam int XAW  = $clog2(MAX_LEN);
  localparam int WCAP = MAX_OUT * MAX_LEN;
  localparam int WAW  = $clog2(WCAP);
  localparam int BAW  = $clog2(MAX_OUT);

  localparam logic [LW-1:0] LANES_L   = LW'(LANES);
  localparam logic [LW-1:0] LANE_MASK = LW'(LANES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_t;

  state_t state, state_n;

  logic [7:0]  x_mem [MAX_LEN];
  logic [7:0]  w_mem [WCAP];
  logic [31:0] b_mem [MAX_OUT];
  logic [31:0] y_mem [MAX_OUT];

  logic [XAW-1:0] x_ptr;
  logic [WAW-1:0] w_ptr;
  logic [BAW-1:0] b_ptr;
  logic [BAW-1:0] rd_ptr;

  logic [LW-1:0]  len_q;
  logic [OW-1:0]  out_q;
  logic           bias_q, rq_q, relu_q;
  logic [4:0]     shift_q;

  logic [LW-1:0]  col;
  logic [OW-1:0]  row;
  logic [WAW-1:0] w_base;
  logic [31:0]    acc;

  logic           cfg_ok, accept, reject, last_col, last_row;
  logic [OW-1:0]  rd_nx;
  logic signed [15:0] prod [LANES];
  logic signed [31:0] lane_sum;
  logic [31:0]    y_post;

  // Rounding shift with int8 saturation, then optional ReLU.
  function automatic logic [31:0] post_proc(input logic [31:0] a, input logic rq,
                                            input logic [4:0] sh, input logic rl);
    logic signed [32:0] s;
    logic signed [32:0] rnd;
    logic [31:0]        t;
    rnd = (sh != 5'd0) ? (33'sd1 <<< (sh - 5'd1)) : 33'sd0;
    s   = $signed({a[31], a}) + rnd;
    s   = s >>> sh;
    if (!rq)                 t = a;
    else if (s > 33'sd127)   t = 32'd127;
    else if (s < -33'sd128)  t = 32'hFFFF_FF80;
    else                     t = s[31:0];
    if (rl && t[31]) t = 32'd0;
    return t;
  endfunction

  assign busy = (state == S_MAC) || (state == S_WB);
  assign done = (state == S_DONE);

  assign cfg_ok = (cfg_len >= LANES_L) && (cfg_len <= LW'(MAX_LEN)) &&
                  ((cfg_len & LANE_MASK) == '0) &&
                  (cfg_out != '0) && (cfg_out <= OW'(MAX_OUT));
  assign accept = (state == S_IDLE) && start && !clear_done && cfg_ok;
  assign reject = (state == S_IDLE) && start && !clear_done && !cfg_ok;

  assign last_col = ((col + LANES_L) == len_q);
  assign last_row = (row == (out_q - OW'(1)));
  assign rd_nx    = OW'(rd_ptr) + OW'(1);

  assign y_post    = post_proc(acc, rq_q, shift_q, relu_q);
  assign y_rd_data = y_mem[rd_ptr];

  // One int8 x int8 product per lane for the current column group.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [XAW-1:0] xc;
    logic [WAW-1:0] wa;
    assign xc      = XAW'(col) + XAW'(k);
    assign wa      = w_base + WAW'(xc);
    assign prod[k] = $signed(x_mem[xc]) * $signed(w_mem[wa]);
  end

  // Reduce the lane products into one wrapping 32-bit partial sum.
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = lane_sum + 32'(prod[k]);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next-state logic; a bad config skips straight to DONE.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept)      state_n = S_MAC;
        else if (reject) state_n = S_DONE;
      end
      S_MAC:  if (last_col) state_n = S_WB;
      S_WB:   state_n = last_row ? S_DONE : S_MAC;
      S_DONE: if (clear_done) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Pointers, latched config, row/column counters and accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_ptr   <= '0;
      w_ptr   <= '0;
      b_ptr   <= '0;
      rd_ptr  <= '0;
      len_q   <= '0;
      out_q   <= '0;
      bias_q  <= 1'b0;
      rq_q    <= 1'b0;
      relu_q  <= 1'b0;
      shift_q <= '0;
      col     <= '0;
      row     <= '0;
      w_base  <= '0;
      acc     <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (!busy && x_wr_en) x_ptr <= (x_ptr == XAW'(MAX_LEN - 1)) ? '0 : x_ptr + XAW'(1);
      if (!busy && w_wr_en) w_ptr <= (w_ptr == WAW'(WCAP - 1)) ? '0 : w_ptr + WAW'(1);
      if (!busy && b_wr_en) b_ptr <= (b_ptr == BAW'(MAX_OUT - 1)) ? '0 : b_ptr + BAW'(1);
      if (y_rd_en)          rd_ptr <= (rd_nx >= out_q) ? '0 : BAW'(rd_nx);
      if (!busy && clear_done) begin
        x_ptr  <= '0;
        w_ptr  <= '0;
        b_ptr  <= '0;
        rd_ptr <= '0;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            len_q   <= cfg_len;
            out_q   <= cfg_out;
            bias_q  <= bias_en;
            rq_q    <= requant_en;
            relu_q  <= relu_en;
            shift_q <= shift;
            cfg_err <= 1'b0;
            col     <= '0;
            row     <= '0;
            w_base  <= '0;
            acc     <= bias_en ? b_mem[0] : '0;
          end else if (reject) begin
            cfg_err <= 1'b1;
          end
        end
        S_MAC: begin
          acc <= acc + lane_sum;
          col <= last_col ? '0 : col + LANES_L;
        end
        S_WB: begin
          if (!last_row) begin
            row    <= row + OW'(1);
            w_base <= w_base + WAW'(len_q);
            acc    <= bias_q ? b_mem[BAW'(row + OW'(1))] : '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand memories and Y write-back; contents are not reset.
  always_ff @(posedge clk) begin
    if (!busy && x_wr_en) x_mem[x_ptr] <= x_wr_data;
    if (!busy && w_wr_en) w_mem[w_ptr] <= w_wr_data;
    if (!busy && b_wr_en) b_mem[b_ptr] <= b_wr_data;
    if (state == S_WB)    y_mem[BAW'(row)] <= y_post;
  end

endmodule

// File: tb/tb_gemv_lanes_core.sv
// tb/tb_gemv_lanes_core.sv - self-checking bench for gemv_lanes_core
module tb_gemv_lanes_core;
  localparam int MAX_LEN = 64;
  localparam int MAX_OUT = 64;
  localparam int LANES   = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        x_wr_en, w_wr_en, b_wr_en;
  logic [7:0]  x_wr_data, w_wr_data;
  logic [31:0] b_wr_data;
  logic [6:0]  cfg_len, cfg_out;
  logic        bias_en, requant_en, relu_en;
  logic [4:0]  shift;
  logic        start, clear_done;
  logic        busy, done, cfg_err;
  logic        y_rd_en;
  logic [31:0] y_rd_data;

  gemv_lanes_core #(.MAX_LEN(MAX_LEN), .MAX_OUT(MAX_OUT), .LANES(LANES)) dut (
    .clk(clk), .reset_n(reset_n),
    .x_wr_en(x_wr_en), .x_wr_data(x_wr_data),
    .w_wr_en(w_wr_en), .w_wr_data(w_wr_data),
    .b_wr_en(b_wr_en), .b_wr_data(b_wr_data),
    .cfg_len(cfg_len), .cfg_out(cfg_out),
    .bias_en(bias_en), .requant_en(requant_en), .shift(shift), .relu_en(relu_en),
    .start(start), .clear_done(clear_done),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .y_rd_en(y_rd_en), .y_rd_data(y_rd_data)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int mx [MAX_LEN];
  int mw [MAX_OUT*MAX_LEN];
  int mb [MAX_OUT];
  int ey [MAX_OUT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear_done = 1'b1;
    step();
    clear_done = 1'b0;
  endtask

  // Streams nx/nw/nb model elements from index 0, x/w/b in parallel.
  task automatic load(input int nx, input int nw, input int nb);
    int n;
    n = (nx > nw) ? nx : nw;
    n = (n > nb) ? n : nb;
    for (int i = 0; i < n; i++) begin
      x_wr_en = (i < nx); x_wr_data = 8'(mx[i % MAX_LEN]);
      w_wr_en = (i < nw); w_wr_data = 8'(mw[i]);
      b_wr_en = (i < nb); b_wr_data = 32'(mb[i % MAX_OUT]);
      step();
    end
    x_wr_en = 1'b0; w_wr_en = 1'b0; b_wr_en = 1'b0;
  endtask

  function automatic int post_model(input int a, input bit rq, input int sh, input bit rl);
    longint t;
    t = a;
    if (rq) begin
      if (sh > 0) t = t + (longint'(1) << (sh - 1));
      t = t >>> sh;
      if (t > 127) t = 127;
      else if (t < -128) t = -128;
    end
    if (rl && t < 0) t = 0;
    return int'(t);
  endfunction

  // Y[r] = post(b[r] + sum_c X[c]*W[r][c]) with wrapping int32 arithmetic.
  task automatic golden(input int len, input int nout, input bit bi, input bit rq,
                        input int sh, input bit rl);
    int acc;
    for (int r = 0; r < nout; r++) begin
      acc = bi ? mb[r] : 0;
      for (int c = 0; c < len; c++) acc += mx[c] * mw[r*len + c];
      ey[r] = post_model(acc, rq, sh, rl);
    end
  endtask

  // Edge count includes the edge at which start is accepted.
  task automatic run(input int len, input int nout, input bit bi, input bit rq,
                     input int sh, input bit rl, output int edges, output bit busy_ok);
    cfg_len = 7'(len); cfg_out = 7'(nout);
    bias_en = bi; requant_en = rq; shift = 5'(sh); relu_en = rl;
    start = 1'b1;
    step();
    start = 1'b0;
    edges = 1;
    busy_ok = 1'b1;
    while (!done && edges < 5000) begin
      if (!busy) busy_ok = 1'b0;
      step();
      edges++;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic read_check(input string tag, input int nout);
    for (int r = 0; r < nout; r++) begin
      chk($sformatf("%s_y%0d", tag, r), y_rd_data, 32'(ey[r]));
      y_rd_en = 1'b1;
      step();
      y_rd_en = 1'b0;
    end
    chk($sformatf("%s_rd_wrap", tag), y_rd_data, 32'(ey[0]));
  endtask

  int  edges;
  bit  bok;
  int  bad_len [5] = '{6, 0, 68, 16, 16};
  int  bad_out [5] = '{4, 4, 4, 0, 65};

  initial begin
    reset_n = 1'b0;
    x_wr_en = 0; w_wr_en = 0; b_wr_en = 0;
    x_wr_data = 0; w_wr_data = 0; b_wr_data = 0;
    cfg_len = 0; cfg_out = 0; bias_en = 0; requant_en = 0; shift = 0; relu_en = 0;
    start = 0; clear_done = 0; y_rd_en = 0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    reset_n = 1'b1;
    step();

    // Deterministic 4x16 with bias.
    for (int c = 0; c < 16; c++) mx[c] = 3*c - 20;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 16; c++) mw[r*16 + c] = 7*r - 2*c;
      mb[r] = r - 5;
    end
    pulse_clear();
    load(16, 64, 4);
    golden(16, 4, 1, 0, 0, 0);
    run(16, 4, 1, 0, 0, 0, edges, bok);
    chk("det_latency", 32'(edges), 32'd21);
    chk("det_busy_throughout", 32'(bok), 32'd1);
    chk("det_cfg_err", 32'(cfg_err), 32'd0);
    read_check("det", 4);

    // clear_done together with start in IDLE: start is dropped.
    pulse_clear();
    cfg_len = 7'd16; cfg_out = 7'd4;
    start = 1'b1; clear_done = 1'b1;
    step();
    start = 1'b0; clear_done = 1'b0;
    chk("clr_wins_busy", 32'(busy), 32'd0);
    chk("clr_wins_done", 32'(done), 32'd0);

    // Extremes: full-length rows of +127*127 and +127*-128.
    for (int c = 0; c < 64; c++) begin
      mx[c] = 127; mw[c] = 127; mw[64 + c] = -128;
    end
    load(64, 128, 0);
    run(64, 2, 0, 0, 0, 0, edges, bok);
    chk("ext_latency", 32'(edges), 32'd35);
    ey[0] = 1032256; ey[1] = -1040384;
    read_check("ext", 2);

    // Requant and ReLU driven through bias with X = 0.
    pulse_clear();
    for (int c = 0; c < 4; c++) mx[c] = 0;
    for (int i = 0; i < 16; i++) mw[i] = int'($urandom_range(0, 255)) - 128;
    mb[0] = 1000; mb[1] = -1000; mb[2] = 40; mb[3] = -5;
    load(4, 16, 4);
    run(4, 4, 1, 1, 4, 0, edges, bok);
    chk("rq_latency", 32'(edges), 32'd9);
    ey[0] = 63; ey[1] = -62; ey[2] = 3; ey[3] = 0;
    read_check("rq4", 4);
    pulse_clear();
    run(4, 4, 1, 1, 2, 0, edges, bok);
    golden(4, 4, 1, 1, 2, 0);
    read_check("rq2_sat", 4);
    pulse_clear();
    run(4, 4, 1, 1, 4, 1, edges, bok);
    ey[0] = 63; ey[1] = 0; ey[2] = 3; ey[3] = 0;
    read_check("rq4_relu", 4);

    // Illegal configurations finish at once and leave Y alone.
    for (int i = 0; i < 5; i++) begin
      pulse_clear();
      cfg_len = 7'(bad_len[i]); cfg_out = 7'(bad_out[i]);
      start = 1'b1;
      step();
      start = 1'b0;
      chk($sformatf("bad%0d_done", i), 32'(done), 32'd1);
      chk($sformatf("bad%0d_cfg_err", i), 32'(cfg_err), 32'd1);
    end
    read_check("bad_y_kept", 4);
    pulse_clear();
    chk("cfg_err_sticky", 32'(cfg_err), 32'd1);
    run(4, 4, 1, 1, 4, 1, edges, bok);
    chk("cfg_err_cleared", 32'(cfg_err), 32'd0);
    read_check("after_bad", 4);

    // Protocol: start/clear_done/w writes while busy are ignored.
    pulse_clear();
    for (int i = 0; i < 64; i++) mw[i] = 55;
    load(0, 64, 0);
    pulse_clear();
    for (int c = 0; c < 16; c++) mx[c] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < 64; i++) mw[i] = int'($urandom_range(0, 255)) - 128;
    mw[63] = -77;
    for (int r = 0; r < 4; r++) mb[r] = int'($urandom);
    load(16, 63, 4);
    cfg_len = 7'd16; cfg_out = 7'd4; bias_en = 1; requant_en = 0; shift = 0; relu_en = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    edges = 1;
    while (!done && edges < 500) begin
      start = (edges == 3); w_wr_en = (edges == 3); w_wr_data = 8'd99;
      clear_done = (edges == 5);
      step();
      edges++;
    end
    start = 1'b0; w_wr_en = 1'b0; clear_done = 1'b0;
    chk("proto_latency", 32'(edges), 32'd21);
    w_wr_en = 1'b1; w_wr_data = 8'(mw[63]);
    step();
    w_wr_en = 1'b0;
    pulse_clear();
    golden(16, 4, 1, 0, 0, 0);
    run(16, 4, 1, 0, 0, 0, edges, bok);
    read_check("proto", 4);

    // Asynchronous reset in the middle of MAC, then a clean rerun.
    pulse_clear();
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    run(16, 4, 1, 0, 0, 0, edges, bok);
    chk("rerun_latency", 32'(edges), 32'd21);
    read_check("rerun", 4);

    // Random 8x32 with bias, seeded.
    void'($urandom(32'hC0FFEE01));
    pulse_clear();
    for (int c = 0; c < 32; c++) mx[c] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < 256; i++) mw[i] = int'($urandom_range(0, 255)) - 128;
    for (int r = 0; r < 8; r++) mb[r] = int'($urandom);
    load(32, 256, 8);
    golden(32, 8, 1, 0, 0, 0);
    run(32, 8, 1, 0, 0, 0, edges, bok);
    chk("rnd_latency", 32'(edges), 32'd73);
    chk("rnd_busy_throughout", 32'(bok), 32'd1);
    read_check("rnd", 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
